// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter.
// Holds the frame FSM encoding and default sizing.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int DEFAULT_DIVIDER = 868;
    localparam int DEFAULT_DATA_W  = 8;
    localparam int FRAME_BITS      = DEFAULT_DATA_W + 2;

    // Counter width that never collapses to zero bits
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..DIVIDER-1 and wraps.
// tick marks the last cycle of each bit period.
module bit_timer
    import serial_pkg::*;
#(
    parameter int DIVIDER = DEFAULT_DIVIDER
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = cnt_w(DIVIDER);
    localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

    logic [CW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == LAST);
    assign tick   = w_last && !clear;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear || w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_tx.sv
// UART-style serial transmitter: start, DATA_W bits LSB first, stop.
// Trigger is only honoured in IDLE; outputs are all registered.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DIVIDER = DEFAULT_DIVIDER,
    parameter int DATA_W  = DEFAULT_DATA_W
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_out,
    output logic              busy,
    output logic              done
);

    localparam int            IW       = cnt_w(DATA_W);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

    tx_state_t         r_state;
    logic [DATA_W-1:0] r_shift;
    logic [IW-1:0]     r_bit_idx;
    logic              r_data_out;
    logic              r_busy;
    logic              r_done;

    logic              w_start;
    logic              w_tick;

    assign w_start  = (r_state == IDLE) && trigger;

    assign data_out = r_data_out;
    assign busy     = r_busy;
    assign done     = r_done;

    // Timer restarts on the accepting edge so the start bit is full width
    bit_timer #(
        .DIVIDER (DIVIDER)
    ) u_timer (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clear  (w_start),
        .tick   (w_tick)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_data_out <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (trigger) begin
                        r_state    <= START;
                        r_shift    <= data_in;
                        r_bit_idx  <= '0;
                        r_busy     <= 1'b1;
                        r_data_out <= 1'b0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state    <= DATA;
                        r_data_out <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == LAST_BIT) begin
                            r_state    <= STOP;
                            r_data_out <= 1'b1;
                        end else begin
                            r_shift    <= r_shift >> 1;
                            r_data_out <= r_shift[1];
                            r_bit_idx  <= r_bit_idx + IW'(1);
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (DIVIDER 4 and 2) checked each
// cycle against a frame-offset reference model, plus directed scenarios.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trig0, trig1;
    logic [7:0] din0, din1;
    logic       dout0, busy0, done0;
    logic       dout1, busy1, done1;

    always #5 clk = ~clk;

    serial_tx #(.DIVIDER(4), .DATA_W(8)) u_d4 (
        .clk_in   (clk),
        .rst_n    (rst_n),
        .trigger  (trig0),
        .data_in  (din0),
        .data_out (dout0),
        .busy     (busy0),
        .done     (done0)
    );

    serial_tx #(.DIVIDER(2), .DATA_W(8)) u_d2 (
        .clk_in   (clk),
        .rst_n    (rst_n),
        .trigger  (trig1),
        .data_in  (din1),
        .data_out (dout1),
        .busy     (busy1),
        .done     (done1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Reference: a frame is the 10-bit word {stop, data, start} sent
    // LSB first, each bit lasting div cycles after the accepting edge.
    int         m_div[2] = '{4, 2};
    int         m_t[2];
    bit         m_act[2];
    bit         m_done[2];
    logic [7:0] m_w[2];

    task automatic m_step(input int i, input logic tr, input logic [7:0] d);
        m_done[i] = 1'b0;
        if (m_act[i]) begin
            m_t[i]++;
            if (m_t[i] == 10 * m_div[i]) begin
                m_act[i]  = 1'b0;
                m_done[i] = 1'b1;
            end
        end else if (tr) begin
            m_act[i] = 1'b1;
            m_t[i]   = 0;
            m_w[i]   = d;
        end
    endtask

    function automatic logic m_line(input int i);
        logic [9:0] f;
        if (!m_act[i]) return 1'b1;
        f = {1'b1, m_w[i], 1'b0};
        return f[m_t[i] / m_div[i]];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i]  = 1'b0;
                m_done[i] = 1'b0;
                m_t[i]    = 0;
            end
        end else begin
            m_step(0, trig0, din0);
            m_step(1, trig1, din1);
        end
    end

    int busy_cnt[2];
    int done_cnt[2];
    int idle_run0 = 0;
    int last_gap0 = 0;

    task automatic cmp(input int i, input logic dout, input logic bsy,
                       input logic dn);
        chk($sformatf("line%0d", i), dout, m_line(i));
        chk($sformatf("busy%0d", i), bsy, m_act[i]);
        chk($sformatf("done%0d", i), dn, m_done[i]);
        chk($sformatf("done_and_busy%0d", i), dn & bsy, 1'b0);
        busy_cnt[i] += int'(bsy);
        done_cnt[i] += int'(dn);
    endtask

    always @(negedge clk) begin
        cmp(0, dout0, busy0, done0);
        cmp(1, dout1, busy1, done1);
        if (!busy0) begin
            idle_run0++;
        end else begin
            if (idle_run0 > 0) last_gap0 = idle_run0;
            idle_run0 = 0;
        end
    end

    int sb[2];
    int sd[2];

    task automatic snap();
        @(posedge clk);
        sb = busy_cnt;
        sd = done_cnt;
    endtask

    task automatic deltas(input string tag, input int i, input int eb,
                          input int ed);
        @(posedge clk);
        chk({tag, "_busy_cycles"}, busy_cnt[i] - sb[i], eb);
        chk({tag, "_done_pulses"}, done_cnt[i] - sd[i], ed);
    endtask

    task automatic pulse(input int i, input logic [7:0] d);
        @(negedge clk);
        if (i == 0) begin trig0 = 1'b1; din0 = d; end
        else        begin trig1 = 1'b1; din1 = d; end
        @(negedge clk);
        if (i == 0) trig0 = 1'b0;
        else        trig1 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        trig0 = 1'b0;
        trig1 = 1'b0;
        din0  = '0;
        din1  = '0;
        repeat (3) @(negedge clk);
        chk("reset_line", dout0, 1'b1);
        chk("reset_busy", busy0, 1'b0);
        rst_n = 1'b1;

        // Idle after reset release
        snap();
        repeat (50) @(negedge clk);
        deltas("idle", 0, 0, 0);

        // Single frame of A5
        snap();
        pulse(0, 8'hA5);
        repeat (45) @(negedge clk);
        deltas("a5", 0, 40, 1);

        // Trigger held: 0F then F0 changed mid-frame
        snap();
        @(negedge clk);
        trig0 = 1'b1;
        din0  = 8'h0F;
        repeat (10) @(negedge clk);
        din0 = 8'hF0;
        repeat (50) @(negedge clk);
        trig0 = 1'b0;
        repeat (40) @(negedge clk);
        deltas("held", 0, 80, 2);
        chk("held_gap", last_gap0, 1);

        // Reset during data bit 3 of a 00 frame
        pulse(0, 8'h00);
        repeat (17) @(posedge clk);
        #1 chk("pre_rst_busy", busy0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_line", dout0, 1'b1);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        snap();
        repeat (5) @(negedge clk);
        pulse(0, 8'h3C);
        repeat (45) @(negedge clk);
        deltas("post_rst", 0, 40, 1);

        // DIVIDER=2 instance, all ones
        snap();
        pulse(1, 8'hFF);
        repeat (25) @(negedge clk);
        deltas("div2_ff", 1, 20, 1);

        // Random triggers, data churn and occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            trig0 = ($urandom_range(0, 15) == 0);
            trig1 = ($urandom_range(0, 11) == 0);
            din0  = 8'($urandom);
            din1  = 8'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        trig0 = 1'b0;
        trig1 = 1'b0;
        repeat (50) @(negedge clk);
        chk("final_idle0", busy0, 1'b0);
        chk("final_idle1", busy1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
